serial_comparator: RTL and testbench

Bit-serial magnitude comparator that processes operands LSB-first, one bit per clock. It runs the opposite direction to the ALU's MSB-first combinational comparator cascade. It produces the same result set: bitwise XOR, equal, a_larger. It adds a start/busy/done handshake and an optional signed mode. It sits beside the ALU for area-constrained compare and branch-condition evaluation where multi-cycle latency is acceptable.

---
 rtl/serial_comparator_if.sv | 24 ++
 rtl/serial_comparator.sv | 103 ++++++++++
 tb/tb_serial_comparator.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/serial_comparator_if.sv
// Request/result bundle for the bit-serial magnitude comparator.
interface serial_comparator_if #(
    parameter int unsigned BIT_COUNT = 8
);
    logic                 start;
    logic [BIT_COUNT-1:0] a;
    logic [BIT_COUNT-1:0] b;
    logic                 is_signed;
    logic                 busy;
    logic                 done;
    logic [BIT_COUNT-1:0] xor_result;
    logic                 equal;
    logic                 a_larger;

    modport master (
        output start, a, b, is_signed,
        input  busy, done, xor_result, equal, a_larger
    );

    modport slave (
        input  start, a, b, is_signed,
        output busy, done, xor_result, equal, a_larger
    );
endinterface

// File: rtl/serial_comparator.sv
// LSB-first bit-serial comparator: one operand bit per clock, start/busy/done
// handshake, optional two's-complement ordering.
module serial_comparator #(
    parameter int unsigned BIT_COUNT = 8
) (
    input logic          clk,
    input logic          rst,
    serial_comparator_if.slave bus
);
    localparam int unsigned CNT_W = (BIT_COUNT > 1) ? $clog2(BIT_COUNT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_COUNT - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t               state;
    logic [BIT_COUNT-1:0] a_sh, b_sh, x_w;
    logic                 eq_w, gt_w, sgn;
    logic [CNT_W-1:0]     cnt;
    logic                 busy_q, done_q, equal_q, a_larger_q;
    logic [BIT_COUNT-1:0] xor_q;

    // Working values after consuming the current bit
    logic                 x_c, eq_next_c, gt_next_c;
    logic [BIT_COUNT-1:0] x_next_c;

    always_comb begin
        x_c       = a_sh[0] ^ b_sh[0];
        x_next_c  = {x_c, x_w[BIT_COUNT-1:1]};
        eq_next_c = eq_w & ~x_c;
        gt_next_c = gt_w;
        // A higher differing bit overrides; the sign bit flips the ordering
        if (x_c)
            gt_next_c = (cnt == LAST && sgn) ? b_sh[0] : a_sh[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            a_sh       <= '0;
            b_sh       <= '0;
            x_w        <= '0;
            eq_w       <= 1'b0;
            gt_w       <= 1'b0;
            sgn        <= 1'b0;
            cnt        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            xor_q      <= '0;
            equal_q    <= 1'b0;
            a_larger_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_sh   <= bus.a;
                        b_sh   <= bus.b;
                        sgn    <= bus.is_signed;
                        x_w    <= '0;
                        eq_w   <= 1'b1;
                        gt_w   <= 1'b0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    x_w  <= x_next_c;
                    eq_w <= eq_next_c;
                    gt_w <= gt_next_c;
                    // Counter holds on the final step so it never wraps
                    if (cnt == LAST) begin
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        xor_q      <= x_next_c;
                        equal_q    <= eq_next_c;
                        a_larger_q <= gt_next_c;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.xor_result = xor_q;
    assign bus.equal      = equal_q;
    assign bus.a_larger   = a_larger_q;
endmodule

// File: tb/tb_serial_comparator.sv
// Scoreboard bench for serial_comparator: driver predicts acceptance and results,
// monitor checks handshake timing every cycle and results on each done pulse.
module tb_serial_comparator;
    localparam int unsigned BC = 8;

    typedef struct packed {
        logic [BC-1:0] x;
        logic          eq;
        logic          gt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   accept_cyc = -1;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t exp_q[$];
    exp_t held = '0;

    serial_comparator_if #(.BIT_COUNT(BC)) bus ();

    serial_comparator #(.BIT_COUNT(BC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [BC-1:0] av, input logic [BC-1:0] bv, input logic sv);
        exp_t e;
        e.x  = av ^ bv;
        e.eq = (av == bv);
        e.gt = sv ? ($signed(av) > $signed(bv)) : (av > bv);
        return e;
    endfunction

    // Accepting edge would be cyc+1; a compare occupies BC+2 edges
    function automatic bit can_accept();
        return (accept_cyc < 0) || ((cyc + 1 - accept_cyc) >= int'(BC + 2));
    endfunction

    task automatic step(input logic st, input logic [BC-1:0] av, input logic [BC-1:0] bv,
                        input logic sv);
        bus.start     = st;
        bus.a         = av;
        bus.b         = bv;
        bus.is_signed = sv;
        if (st && can_accept()) begin
            accept_cyc = cyc + 1;
            exp_q.push_back(model(av, bv, sv));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_step();
        step(1'b0, BC'($urandom), BC'($urandom), 1'($urandom));
    endtask

    task automatic issue(input logic [BC-1:0] av, input logic [BC-1:0] bv, input logic sv);
        while (!can_accept()) idle_step();
        step(1'b1, av, bv, sv);
    endtask

    // Monitor: handshake timing every cycle, results popped on done, held otherwise
    always @(negedge clk) begin
        int ph;
        if (rst) begin
            chk("rst_busy", 32'(bus.busy), 0);
            chk("rst_done", 32'(bus.done), 0);
            chk("rst_xor", 32'(bus.xor_result), 0);
            chk("rst_equal", 32'(bus.equal), 0);
            chk("rst_a_larger", 32'(bus.a_larger), 0);
        end else begin
            ph = (accept_cyc < 0) ? -100 : (cyc - accept_cyc);
            chk("busy", 32'(bus.busy), 32'(ph >= 0 && ph <= int'(BC) - 1));
            chk("done", 32'(bus.done), 32'(ph == int'(BC)));
            if (bus.done === 1'b1) begin
                if (exp_q.size() == 0) chk("done_unexpected", 1, 0);
                else held = exp_q.pop_front();
            end
            chk("xor_result", 32'(bus.xor_result), 32'(held.x));
            chk("equal", 32'(bus.equal), 32'(held.eq));
            chk("a_larger", 32'(bus.a_larger), 32'(held.gt));
        end
    end

    initial begin
        int a0;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.is_signed = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) idle_step();

        // Directed cases
        issue(8'h5A, 8'h5A, 1'b0);
        issue(8'h80, 8'h7F, 1'b0);
        issue(8'h80, 8'h7F, 1'b1);
        issue(8'h01, 8'h02, 1'b0);
        issue(8'h03, 8'h02, 1'b0);
        issue(8'h7F, 8'h80, 1'b1);
        issue(8'hFF, 8'hFE, 1'b1);

        // start held high with fresh operands every cycle
        for (int i = 0; i < 45; i++) step(1'b1, BC'($urandom), BC'($urandom), 1'($urandom));
        step(1'b0, '0, '0, 1'b0);

        // Reset in the 4th SHIFT cycle
        issue(8'hFF, 8'h00, 1'b0);
        a0 = accept_cyc;
        while (cyc < a0 + 3) idle_step();
        #1 rst = 1'b1;
        #1;
        chk("async_rst_busy", 32'(bus.busy), 0);
        chk("async_rst_done", 32'(bus.done), 0);
        chk("async_rst_xor", 32'(bus.xor_result), 0);
        chk("async_rst_equal", 32'(bus.equal), 0);
        chk("async_rst_a_larger", 32'(bus.a_larger), 0);
        exp_q.delete();
        accept_cyc = -1;
        held = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (12) idle_step();
        issue(8'hFF, 8'h00, 1'b0);
        issue(8'h3C, 8'h3C, 1'b1);

        // Random regression with occasional idle gaps
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) idle_step();
            issue(BC'($urandom), BC'($urandom), 1'($urandom));
        end

        for (int i = 0; i < 30 && exp_q.size() != 0; i++) idle_step();
        chk("drain_pending", 32'(exp_q.size()), 0);
        repeat (3) idle_step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
